// File: rtl/audio_sample_buffer.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : audio_sample_buffer
// Description : Stereo-to-mono mixer feeding a small sample FIFO that sits
//               directly upstream of the DFT front end. Absorbs the phase
//               difference between codec sample timing and the DFT read
//               cadence, and counts samples dropped on overflow.
//
// Optional    : define AUDIO_DC_BLOCK_EN to insert a first-order DC-removal
//               stage between the mix register and the FIFO (adds one cycle
//               of latency).
//
// Parameters  : N        - sample width in bits
//               DEPTH    - FIFO entries (power of 2, >= 2)
//               DC_SHIFT - DC estimator time constant (shift amount)
//
// Ports       : clk          in   system clock
//               rst          in   asynchronous active-high reset
//               leftIn       in   left-channel sample (signed, N bits)
//               rightIn      in   right-channel sample (signed, N bits)
//               audioValid   in   strobe: leftIn/rightIn valid this cycle
//               doingRead    in   strobe: pop the head entry
//               inputSample  out  head-of-FIFO sample (valid with sampleReady)
//               sampleReady  out  FIFO not empty
//               fillLevel    out  current entry count (registered)
//               dropCount    out  overflow drop count, saturating at 255
//
// Revision    : 1.0 - initial release
// ============================================================================
module audio_sample_buffer #(
  parameter int N        = 16,
  parameter int DEPTH    = 8,
  parameter int DC_SHIFT = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [N-1:0]        leftIn,
  input  logic signed [N-1:0]        rightIn,
  input  logic                       audioValid,
  input  logic                       doingRead,
  output logic signed [N-1:0]        inputSample,
  output logic                       sampleReady,
  output logic [$clog2(DEPTH):0]     fillLevel,
  output logic [7:0]                 dropCount
);

  localparam int c_ADDR_W = $clog2(DEPTH);

  // --------------------------------------------------------------------------
  // Mix stage: sum at N+1 bits so it cannot overflow, then an arithmetic
  // shift gives floor((l+r)/2), which always fits back into N bits.
  // --------------------------------------------------------------------------
  logic signed [N:0]   w_sum;
  logic signed [N-1:0] w_mono;
  logic signed [N-1:0] r_mix_reg;
  logic                r_mix_v;

  assign w_sum  = $signed({leftIn[N-1], leftIn}) + $signed({rightIn[N-1], rightIn});
  assign w_mono = N'(w_sum >>> 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mix_v   <= 1'b0;
      r_mix_reg <= '0;
    end else begin
      r_mix_v <= audioValid;
      if (audioValid) begin
        r_mix_reg <= w_mono;
      end
    end
  end

  // Sample presented to the FIFO write port
  logic                w_push_v;
  logic signed [N-1:0] w_push_data;

`ifdef AUDIO_DC_BLOCK_EN
  // --------------------------------------------------------------------------
  // DC removal: acc tracks the running DC scaled by 2^DC_SHIFT. The estimate
  // is subtracted from each sample and the (unsaturated) difference feeds
  // back into acc, giving a leaky high-pass with pole 1 - 2^-DC_SHIFT.
  // --------------------------------------------------------------------------
  localparam int c_ACC_W = N + DC_SHIFT;

  logic signed [c_ACC_W-1:0] r_acc;
  logic signed [N-1:0]       w_dc;
  logic signed [N:0]         w_diff;
  logic signed [N-1:0]       w_sat;
  logic signed [N-1:0]       r_dc_y;
  logic                      r_dc_v;

  assign w_dc   = N'(r_acc >>> DC_SHIFT);
  assign w_diff = $signed({r_mix_reg[N-1], r_mix_reg}) - $signed({w_dc[N-1], w_dc});

  // Overflow into N bits shows up as the top two bits of the difference
  // disagreeing; the top bit then gives the clamp direction.
  always_comb begin
    w_sat = w_diff[N-1:0];
    if (w_diff[N] != w_diff[N-1]) begin
      w_sat = w_diff[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc  <= '0;
      r_dc_y <= '0;
      r_dc_v <= 1'b0;
    end else begin
      r_dc_v <= r_mix_v;
      if (r_mix_v) begin
        r_dc_y <= w_sat;
        r_acc  <= r_acc + {{(DC_SHIFT-1){w_diff[N]}}, w_diff};
      end
    end
  end

  assign w_push_v    = r_dc_v;
  assign w_push_data = r_dc_y;
`else
  logic [31:0] w_unused_dc_shift;

  assign w_unused_dc_shift = 32'(DC_SHIFT);
  assign w_push_v          = r_mix_v;
  assign w_push_data       = r_mix_reg;
`endif

  // --------------------------------------------------------------------------
  // FIFO: pointers carry one extra wrap bit so full and empty are
  // distinguishable without a separate counter.
  // --------------------------------------------------------------------------
  logic [N-1:0]      r_mem [DEPTH];
  logic [c_ADDR_W:0] r_wr_ptr;
  logic [c_ADDR_W:0] r_rd_ptr;
  logic [c_ADDR_W:0] r_fill_level;
  logic [7:0]        r_drop_count;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]) &&
                   (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]);

  // A pop in the same cycle frees the head slot, so a push into a full FIFO
  // still lands. The write goes to the slot being popped, which is safe
  // because the head is read combinationally before the edge.
  assign w_pop  = doingRead && !w_empty;
  assign w_push = w_push_v && (!w_full || w_pop);
  assign w_drop = w_push_v && w_full && !w_pop;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= w_push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fill_level <= '0;
      r_drop_count <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_fill_level <= r_fill_level + 1'b1;
        2'b01:   r_fill_level <= r_fill_level - 1'b1;
        default: r_fill_level <= r_fill_level;
      endcase
      if (w_drop && (r_drop_count != 8'hFF)) begin
        r_drop_count <= r_drop_count + 8'd1;
      end
    end
  end

  assign inputSample = r_mem[r_rd_ptr[c_ADDR_W-1:0]];
  assign sampleReady = !w_empty;
  assign fillLevel   = r_fill_level;
  assign dropCount   = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_audio_sample_buffer.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : tb_audio_sample_buffer
// Description : Directed self-checking bench for audio_sample_buffer.
//               Builds against either configuration of AUDIO_DC_BLOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_sample_buffer;

  localparam int N        = 16;
  localparam int DEPTH    = 8;
  localparam int DC_SHIFT = 4;
`ifdef AUDIO_DC_BLOCK_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic signed [N-1:0] leftIn;
  logic signed [N-1:0] rightIn;
  logic                audioValid;
  logic                doingRead;
  logic signed [N-1:0] inputSample;
  logic                sampleReady;
  logic [3:0]          fillLevel;
  logic [7:0]          dropCount;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  audio_sample_buffer #(
    .N        (N),
    .DEPTH    (DEPTH),
    .DC_SHIFT (DC_SHIFT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .leftIn      (leftIn),
    .rightIn     (rightIn),
    .audioValid  (audioValid),
    .doingRead   (doingRead),
    .inputSample (inputSample),
    .sampleReady (sampleReady),
    .fillLevel   (fillLevel),
    .dropCount   (dropCount)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; land 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle strobe; returns in the cycle after the strobe.
  task automatic push_pair(input int l, input int r);
    leftIn     = N'(l);
    rightIn    = N'(r);
    audioValid = 1'b1;
    tick();
    audioValid = 1'b0;
  endtask

  task automatic pop();
    doingRead = 1'b1;
    tick();
    doingRead = 1'b0;
  endtask

  // Back-to-back strobes with left=right=first+i, then drain the pipeline.
  task automatic push_burst(input int first, input int count);
    for (int i = 0; i < count; i++) begin
      leftIn     = N'(first + i);
      rightIn    = N'(first + i);
      audioValid = 1'b1;
      tick();
    end
    audioValid = 1'b0;
    repeat (LAT) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  int mix_l [4] = '{100, -3, 32767, -32768};
  int mix_r [4] = '{200,  0, 32767, -32768};
  int mix_e [4] = '{150, -2, 32767, -32768};
  int exp_q [8] = '{22, 23, 24, 25, 26, 27, 28, 99};
  int y;

  initial begin
    rst        = 1'b1;
    leftIn     = '0;
    rightIn    = '0;
    audioValid = 1'b0;
    doingRead  = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_ready", int'(sampleReady), 0);
    check("reset_fill",  int'(fillLevel),   0);
    check("reset_drop",  int'(dropCount),   0);

    // ---------------- latency ----------------
    repeat (2) tick();
    push_pair(5, 5);
    check("lat_t1_ready", int'(sampleReady), 0);
    repeat (LAT - 2) begin
      tick();
      check("lat_t2_ready", int'(sampleReady), 0);
    end
    tick();
    check("lat_ready_rise", int'(sampleReady), 1);
    check("lat_fill",       int'(fillLevel),   1);
    check("lat_value",      int'(inputSample), 5);
    repeat (3) tick();
    pop();
    check("lat_ready_fall", int'(sampleReady), 0);
    check("lat_fill_zero",  int'(fillLevel),   0);

`ifndef AUDIO_DC_BLOCK_EN
    // ---------------- mix rounding ----------------
    for (int i = 0; i < 4; i++) begin
      push_pair(mix_l[i], mix_r[i]);
      repeat (LAT - 1) tick();
      check("mix_ready", int'(sampleReady), 1);
      check("mix_value", int'(inputSample), mix_e[i]);
      pop();
      check("mix_empty", int'(sampleReady), 0);
    end

    // ---------------- overflow ----------------
    push_burst(1, 10);
    check("ovf_fill", int'(fillLevel), 8);
    check("ovf_drop", int'(dropCount), 2);
    for (int k = 1; k <= 8; k++) begin
      check("ovf_order", int'(inputSample), k);
      pop();
    end
    check("ovf_drained_fill",  int'(fillLevel),   0);
    check("ovf_drained_ready", int'(sampleReady), 0);

    // ---------------- full with push+pop in one cycle ----------------
    push_burst(21, 8);
    check("full_fill", int'(fillLevel), 8);
    push_pair(99, 99);
    doingRead = 1'b1;          // coincides with the mix-stage push
    tick();
    doingRead = 1'b0;
    check("full_pp_fill", int'(fillLevel), 8);
    check("full_pp_drop", int'(dropCount), 2);
    for (int i = 0; i < 8; i++) begin
      check("full_pp_order", int'(inputSample), exp_q[i]);
      pop();
    end
    check("full_pp_drained", int'(fillLevel), 0);

    // ---------------- drop counter saturation ----------------
    push_burst(7, 308);
    check("sat_drop", int'(dropCount), 255);
    check("sat_fill", int'(fillLevel), 8);
    doingRead = 1'b1;
    repeat (8) tick();
    doingRead = 1'b0;
    check("sat_drained", int'(fillLevel), 0);

    // ---------------- empty with push+pop in one cycle ----------------
    push_pair(4, 4);
    doingRead = 1'b1;
    tick();
    doingRead = 1'b0;
    check("empty_pp_fill",  int'(fillLevel),   1);
    check("empty_pp_ready", int'(sampleReady), 1);
    check("empty_pp_value", int'(inputSample), 4);
    pop();

    // ---------------- reads on an empty FIFO ----------------
    doingRead = 1'b1;
    repeat (20) tick();
    doingRead = 1'b0;
    check("empty_rd_fill",  int'(fillLevel),   0);
    check("empty_rd_ready", int'(sampleReady), 0);
    check("empty_rd_drop",  int'(dropCount),   255);
    push_pair(6, 8);
    repeat (LAT - 1) tick();
    check("empty_rd_after_val",  int'(inputSample), 7);
    check("empty_rd_after_fill", int'(fillLevel),   1);
    pop();
`else
    // ---------------- DC removal: constant input decays ----------------
    do_reset();
    for (int i = 0; i < 200; i++) begin
      push_pair(1000, 1000);
      repeat (LAT - 1) tick();
      y = int'(inputSample);
      if (i == 0)   check("dc_first",  y, 1000);
      if (i == 1)   check("dc_second", y, 938);
      if (i == 2)   check("dc_third",  y, 879);
      if (i == 199) check("dc_last_small", int'(y >= -1 && y <= 1), 1);
      pop();
    end

    // ---------------- DC removal: negative clamp ----------------
    do_reset();
    for (int i = 0; i < 100; i++) begin
      push_pair(32767, 32767);
      repeat (LAT - 1) tick();
      if (i == 0) check("dc_pos_first", int'(inputSample), 32767);
      pop();
    end
    push_pair(-32768, -32768);
    repeat (LAT - 1) tick();
    check("dc_clamp_ready", int'(sampleReady), 1);
    check("dc_clamp_value", int'(inputSample), -32768);
    pop();
`endif

    // ---------------- asynchronous reset mid-stream ----------------
    push_burst(11, 3);
    check("arst_pre_fill", int'(fillLevel), 3);
    #2;
    rst = 1'b1;
    #1;
    check("arst_ready", int'(sampleReady), 0);
    check("arst_fill",  int'(fillLevel),   0);
    check("arst_drop",  int'(dropCount),   0);
    tick();
    rst = 1'b0;
    tick();
    check("arst_post_fill", int'(fillLevel), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/audio_sample_buffer.md
# audio_sample_buffer

Sits directly upstream of the DFT front end. Accepts stereo sample pairs from the audio codec interface, mixes them to mono, and queues them in a small FIFO. Presents the head sample as `inputSample` with `sampleReady`, and pops one entry on each `doingRead` strobe from the consumer. Absorbs the phase difference between codec sample timing and the DFT read cadence, and counts dropped samples for debug.

## Interface
Parameters:
- `N`, 16: sample width in bits.
- `DEPTH`, 8: FIFO entries. Must be a power of 2 and ≥2.
- `DC_SHIFT`, 10: DC-estimator time constant, as a shift amount. Only used with `AUDIO_DC_BLOCK_EN`.

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: reset. Asynchronous, active-high.
- `leftIn`  in  N signed: left-channel sample.
- `rightIn`  in  N signed: right-channel sample.
- `audioValid`  in  1: one-cycle strobe; `leftIn`/`rightIn` are valid this cycle.
- `doingRead`  in  1: one-cycle strobe from the consumer; pops the head entry.
- `inputSample`  out  N signed: head-of-FIFO sample.
- `sampleReady`  out  1: FIFO not empty.
- `fillLevel`  out  $clog2(DEPTH)+1: current entry count.
- `dropCount`  out  8: samples dropped on overflow. Saturates at 255.

## Operation
- Mix: `mono = (leftIn + rightIn) >>> 1`.
  - Sum is computed at N+1 bits; arithmetic shift, floor rounding. Example: (-3 + 0) gives -2.
  - Result always fits in N bits.
- Mix stage: `mono` is registered into `mixReg` with a valid flag `mixV` on `audioValid`. `mixV` is a one-cycle pulse.
- Push: when `mixV` is high, `mixReg` (or the DC-blocked value) is written at `wrPtr`.
- Pop: when `doingRead` is high and the FIFO is non-empty, `rdPtr` advances.
- Pointers are $clog2(DEPTH)+1 bits.
  - Empty: `wrPtr == rdPtr`.
  - Full: `wrPtr` and `rdPtr` differ only in the MSB.
  - Wrap-around uses natural modulo overflow.
- `inputSample` is the combinational read of `mem[rdPtr]`. It is held stable while `sampleReady` is high and no pop occurs.
- `inputSample` is don't-care while `sampleReady` is low. The bench must not check it then.
- Boundary cases:
  - Push when full with no pop: the new sample is discarded, `dropCount` increments (saturating), and FIFO contents are unchanged.
  - Push and pop in the same cycle when full: both occur, `fillLevel` is unchanged, no drop.
  - Push and pop in the same cycle when empty: the pop is ignored and the push occurs, so `fillLevel` becomes 1.
  - `doingRead` when empty: ignored. No pointer move, no error flag.
  - Push and pop in the same cycle, non-empty and not full: `fillLevel` is unchanged.
- `audioValid` arriving on consecutive cycles is legal. Each cycle produces one push.

## Timing
- Reset (async assert; release synchronized to `clk` upstream) clears:
  - `wrPtr`, `rdPtr`, `mixV`, `mixReg`
  - `dropCount` = 0, `fillLevel` = 0, `sampleReady` = 0
  - `inputSample` reads `mem[0]`, don't-care
  - FIFO memory is not cleared.
- Reset mid-operation discards all queued samples and any sample in the mix stage.
- Latency without DC block:
  - `audioValid` in cycle t sets `mixV` in t+1.
  - The entry is written at the end of t+1.
  - `sampleReady` rises in t+2 if the FIFO was empty.
- Latency with DC block: one extra register stage, so `sampleReady` rises in t+3.
- `doingRead` in cycle t moves `rdPtr` at the end of t. The new head appears in t+1; `sampleReady` falls in t+1 if that pop emptied the FIFO.
- `fillLevel` and `dropCount` are registered outputs and update one cycle after the causing event's edge.

## Configuration
- `AUDIO_DC_BLOCK_EN` defined: a DC-removal stage is inserted between the mix stage and the FIFO.
  - Accumulator `acc` is signed N+DC_SHIFT bits, reset to 0.
  - `dc = acc >>> DC_SHIFT`.
  - On each valid sample: `y = sat_N(mono - dc)`, then `acc <= acc + (mono - dc)`.
  - Difference is computed at N+1 bits; `sat_N` clamps to [-2^(N-1), 2^(N-1)-1].
  - `y` is registered and pushed one cycle after `mixV`.
- `AUDIO_DC_BLOCK_EN` undefined: `mixReg` is pushed directly. No accumulator logic is present.

## Test plan
- Reset then idle: `sampleReady`=0, `fillLevel`=0, `dropCount`=0. Assert `rst` mid-stream with 3 queued entries: outputs return to these values immediately, with no clock edge.
- Mix rounding: pairs (100, 200), (-3, 0), (32767, 32767), (-32768, -32768), each followed by `doingRead` → `inputSample` = 150, -2, 32767, -32768 (DC block off).
- Latency: single `audioValid` at cycle 10 into an empty FIFO → `sampleReady` high at cycle 12; `doingRead` at 15 → `sampleReady` low at 16, `fillLevel` 0 at 16.
- Overflow: DEPTH=8, 10 strobes with no reads, samples 1..10 → `fillLevel`=8, `dropCount`=2; 8 reads return 1..8 in order. 300 further overflow pushes → `dropCount`=255.
- Simultaneous events:
  - Full FIFO with push+pop in one cycle → `fillLevel` stays 8, `dropCount` unchanged, the new sample is last out.
  - Empty FIFO with `doingRead`+`mixV` in one cycle → `fillLevel`=1.
  - 20 reads on an empty FIFO → no change.
- DC block (macro on, DC_SHIFT=4): constant input 1000 on both channels for 200 samples → the first output is 1000 and magnitudes decay toward 0, with the last output |y| ≤ 1. Input -32768 after reset with large positive `acc` → output clamps to -32768.
